rf68000_nic_initiator: RTL and testbench

- Bus initiator for the node-side NIC port. It turns single-word read/write requests arriving from the ring network interface into cyc/stb transactions on the node arbiter's NIC port (nic_*), then returns one response per request.
- Enforces one outstanding transaction, a bus timeout and a minimum idle gap after each transaction so the CPU port of the arbiter is not starved.

---
 rtl/rf68000_nic_initiator.sv | 121 ++++++++++++
 tb/tb_rf68000_nic_initiator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rf68000_nic_initiator.sv
// Single-outstanding bus initiator: ring requests become cyc/stb cycles on the arbiter NIC port.
// nic_cyc rises one cycle after acceptance; responses are held until rsp_ready; a timeout and a minimum idle gap follow.
module rf68000_nic_initiator #(
  parameter int unsigned TIMEOUT  = 256,
  parameter int unsigned GAP      = 2,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        nic_cyc,
  output logic        nic_stb,
  output logic        nic_we,
  output logic [3:0]  nic_sel,
  output logic [31:0] nic_adr,
  output logic [31:0] nic_dato,
  input  logic [31:0] nic_dati,
  input  logic        nic_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RSP, S_GAP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);

  state_t      state_q;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] gap_q, gap_d;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_dat_q;
  logic        nic_cyc_q, nic_stb_q, nic_we_q;
  logic [3:0]  nic_sel_q;
  logic [31:0] nic_adr_q, nic_dato_q;

  assign tmo_d = tmo_q + 16'd1;
  assign gap_d = (gap_q == 16'hFFFF) ? gap_q : gap_q + 16'd1;

  assign req_ready = rst_ni && (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign nic_cyc   = nic_cyc_q;
  assign nic_stb   = nic_stb_q;
  assign nic_we    = nic_we_q;
  assign nic_sel   = nic_sel_q;
  assign nic_adr   = nic_adr_q;
  assign nic_dato  = nic_dato_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      gap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      nic_cyc_q   <= 1'b0;
      nic_stb_q   <= 1'b0;
      nic_we_q    <= 1'b0;
      nic_sel_q   <= '0;
      nic_adr_q   <= '0;
      nic_dato_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            nic_cyc_q  <= 1'b1;
            nic_stb_q  <= 1'b1;
            nic_we_q   <= req_we;
            nic_sel_q  <= req_sel;
            nic_adr_q  <= req_adr;
            nic_dato_q <= req_dat;
            tmo_q      <= '0;
            state_q    <= S_BUS;
          end
        end
        S_BUS: begin
          // An ack arriving on the timeout cycle still completes normally.
          if (nic_ack || tmo_q == TMO_LAST) begin
            rsp_dat_q   <= nic_ack ? (nic_we_q ? 32'd0 : nic_dati) : ERR_DATA;
            rsp_err_q   <= !nic_ack;
            rsp_valid_q <= 1'b1;
            nic_cyc_q   <= 1'b0;
            nic_stb_q   <= 1'b0;
            nic_we_q    <= 1'b0;
            nic_sel_q   <= '0;
            state_q     <= S_RSP;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            gap_q       <= '0;
            state_q     <= S_GAP;
          end
        end
        S_GAP: begin
          // A lingering ack from the arbiter keeps us idle until it clears.
          if (gap_q >= GAP_LAST && !nic_ack) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf68000_nic_initiator.sv
// Randomized bench for rf68000_nic_initiator with a transaction-level reference model.
module tb_rf68000_nic_initiator;
  localparam int TMO = 8;
  localparam int GP  = 2;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [3:0]  req_sel = '0;
  logic [31:0] req_adr = '0, req_dat = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        nic_cyc, nic_stb, nic_we;
  logic [3:0]  nic_sel;
  logic [31:0] nic_adr, nic_dato;
  logic [31:0] nic_dati = '0;
  logic        nic_ack = 1'b0;

  rf68000_nic_initiator #(.TIMEOUT(TMO), .GAP(GP), .ERR_DATA(ERRD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_sel(req_sel),
    .req_adr(req_adr), .req_dat(req_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .nic_cyc(nic_cyc), .nic_stb(nic_stb), .nic_we(nic_we), .nic_sel(nic_sel),
    .nic_adr(nic_adr), .nic_dato(nic_dato), .nic_dati(nic_dati), .nic_ack(nic_ack)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Length of the most recent run of cycles with nic_cyc low.
  int low_run = 0;
  int last_low = 0;
  always @(negedge clk_i) begin
    #1;
    if (nic_cyc) begin
      if (low_run != 0) last_low = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  int exp_low = 0;
  bit low_known = 1'b0;

  // k: cycle index (0 = first stb cycle) at which the arbiter acks for one cycle.
  // late: cycles of stale ack raised at the start of the idle gap.
  task automatic txn(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [31:0] dati,
                     input int k, input int rsp_wait, input int late);
    int dur, gcnt, exp_g, n;
    bit err;
    logic [31:0] exp_dat;
    err     = (k >= TMO);
    dur     = err ? TMO : k + 1;
    exp_dat = err ? ERRD : (we ? 32'd0 : dati);

    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk_i); n++; end
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_sel = sel; req_adr = adr; req_dat = dat;
    @(negedge clk_i);
    req_valid = 1'b0; req_we = $urandom; req_sel = $urandom; req_adr = $urandom; req_dat = $urandom;
    chk("req_ready_busy", req_ready, 0);

    for (int i = 0; i < dur; i++) begin
      nic_ack  = (i == k);
      nic_dati = (i == k) ? dati : $urandom;
      chk("bus_cyc", nic_cyc, 1);
      chk("bus_stb", nic_stb, 1);
      chk("bus_we", nic_we, we);
      chk("bus_sel", nic_sel, sel);
      chk("bus_adr", nic_adr, adr);
      chk("bus_dato", nic_dato, dat);
      @(negedge clk_i);
    end
    nic_ack = 1'b0; nic_dati = $urandom;

    chk("drop_cyc", nic_cyc, 0);
    chk("drop_stb", nic_stb, 0);
    chk("drop_we", nic_we, 0);
    chk("drop_sel", nic_sel, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_dat", rsp_dat, exp_dat);
    chk("rsp_err", rsp_err, err);
    if (low_known) begin
      chk("cyc_low_run", last_low, exp_low);
      chk("cyc_low_min", last_low >= GP, 1);
    end

    for (int i = 0; i < rsp_wait; i++) begin
      rsp_ready = 1'b0;
      @(negedge clk_i);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_dat", rsp_dat, exp_dat);
      chk("hold_err", rsp_err, err);
      chk("hold_ready", req_ready, 0);
      chk("hold_cyc", nic_cyc, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk_i);
    rsp_ready = 1'b0;
    chk("rsp_done", rsp_valid, 0);

    gcnt = 0;
    while (!req_ready && gcnt < 100) begin
      nic_ack = (gcnt < late);
      chk("gap_cyc", nic_cyc, 0);
      gcnt++;
      @(negedge clk_i);
    end
    nic_ack = 1'b0;
    exp_g = (((GP - 1) > late) ? (GP - 1) : late) + 1;
    chk("gap_cycles", gcnt, exp_g);
    exp_low   = (rsp_wait + 1) + exp_g + 1;
    low_known = 1'b1;
  endtask

  initial begin
    int k, w, l;
    logic [3:0] s;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_cyc", nic_cyc, 0);
    chk("rst_stb", nic_stb, 0);
    chk("rst_we", nic_we, 0);
    chk("rst_sel", nic_sel, 0);
    chk("rst_adr", nic_adr, 0);
    chk("rst_dato", nic_dato, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rel_ready", req_ready, 1);

    txn(1'b0, 4'hF, 32'hFF100010, 32'h0, 32'h12345678, 4, 0, 0);
    txn(1'b1, 4'b0011, 32'h00000020, 32'hCAFEBABE, 32'h55AA55AA, 3, 0, 0);
    txn(1'b0, 4'hF, 32'h00000040, 32'h0, 32'h11111111, 20, 0, 3);
    txn(1'b0, 4'h1, 32'h00000044, 32'h0, 32'h22222222, 2, 0, 0);
    txn(1'b1, 4'h0, 32'h00000048, 32'h33333333, 32'h0, 2, 0, 0);
    txn(1'b0, 4'hC, 32'h0000004C, 32'h0, 32'h44444444, 5, 10, 0);
    txn(1'b0, 4'hF, 32'h00000050, 32'h0, 32'h66666666, TMO - 1, 0, 0);
    txn(1'b0, 4'hF, 32'h00000054, 32'h0, 32'h77777777, TMO, 1, 1);

    // Reset while the bus cycle is open.
    while (!req_ready) @(negedge clk_i);
    req_valid = 1'b1; req_we = 1'b0; req_sel = 4'hF; req_adr = 32'h100; req_dat = 32'h0;
    @(negedge clk_i);
    req_valid = 1'b0;
    chk("mid_cyc_open", nic_cyc, 1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_cyc", nic_cyc, 0);
    chk("mid_rst_stb", nic_stb, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("mid_rel_ready", req_ready, 1);
    chk("mid_rel_valid", rsp_valid, 0);
    low_known = 1'b0;

    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, TMO + 2);
      w = $urandom_range(0, 3);
      l = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      s = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      txn(1'($urandom), s, $urandom, $urandom, $urandom, k, w, l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
